// File: rtl/tpg_pkg.sv
// Shared TPG definitions: pattern mode codes, VGA 640x480 timing
// and the button debounce state encoding.
package tpg_pkg;

  localparam int MODE_W = 2;

  typedef logic [MODE_W-1:0] mode_t;

  localparam mode_t MODE_BARS  = 2'd0;
  localparam mode_t MODE_GRID  = 2'd1;
  localparam mode_t MODE_CHECK = 2'd2;
  localparam mode_t MODE_CHAR  = 2'd3;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_H_TOTAL  = 800;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam int VGA_V_TOTAL  = 525;

  typedef enum logic [1:0] {
    S_LOW,
    S_WAIT_HIGH,
    S_HIGH,
    S_WAIT_LOW
  } db_state_t;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, then a level FSM that
// needs DEBOUNCE_CYCLES stable cycles to accept an edge.
module btn_debounce
  import tpg_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press,
  output logic level
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic          synced;
  db_state_t     state;
  logic [CW-1:0] cnt;

  assign synced = sync[1];
  assign level  = (state == S_HIGH) || (state == S_WAIT_LOW);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= '0;
      state <= S_LOW;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], btn};
      press <= 1'b0;
      unique case (state)
        S_LOW: begin
          if (synced) begin
            state <= S_WAIT_HIGH;
            cnt   <= '0;
          end
        end
        S_WAIT_HIGH: begin
          if (!synced) begin
            state <= S_LOW;
          end else if (cnt == LAST) begin
            state <= S_HIGH;
            press <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_HIGH: begin
          if (!synced) begin
            state <= S_WAIT_LOW;
            cnt   <= '0;
          end
        end
        S_WAIT_LOW: begin
          if (synced) begin
            state <= S_HIGH;
          end else if (cnt == LAST) begin
            state <= S_LOW;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_LOW;
      endcase
    end
  end

endmodule

// File: rtl/tpg_mode_ctrl.sv
// Frame-synchronous pattern mode controller: button, auto-cycle and
// host load requests are queued and applied only at vblank start.
module tpg_mode_ctrl
  import tpg_pkg::*;
#(
  parameter int unsigned V_ACTIVE        = VGA_V_ACTIVE,
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned AUTO_FRAMES     = 120,
  parameter int unsigned NUM_MODES       = 4
) (
  input  logic              clk_pix,
  input  logic              resetn,
  input  logic [9:0]        hcount,
  input  logic [9:0]        vcount,
  input  logic              btn_next,
  input  logic              auto_en,
  input  logic              load_req,
  input  logic [MODE_W-1:0] load_mode,
  output logic [MODE_W-1:0] mode,
  output logic              mode_changed,
  output logic              pending
);

  localparam int FW = $clog2(AUTO_FRAMES + 1);
  localparam logic [FW-1:0] FLAST = FW'(AUTO_FRAMES - 1);
  localparam mode_t MLAST = MODE_W'(NUM_MODES - 1);

  logic          vb_pulse;
  logic          btn_press;
  logic          next_pend;
  logic          load_pend;
  mode_t         load_val;
  mode_t         mode_nx;
  logic          auto_exp;
  logic [FW-1:0] frame_cnt;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db (
    .clk  (clk_pix),
    .rst_n(resetn),
    .btn  (btn_next),
    .press(btn_press),
    .level()
  );

  assign auto_exp = vb_pulse && auto_en && (frame_cnt == FLAST);
  assign pending  = next_pend | load_pend;

  // Host load outranks any advance; button and auto collapse to one +1.
  always_comb begin
    mode_nx = mode;
    if (load_pend)
      mode_nx = load_val;
    else if (next_pend || auto_exp)
      mode_nx = (mode == MLAST) ? '0 : mode + 1'b1;
  end

  always_ff @(posedge clk_pix or negedge resetn) begin
    if (!resetn) begin
      vb_pulse     <= 1'b0;
      frame_cnt    <= '0;
      next_pend    <= 1'b0;
      load_pend    <= 1'b0;
      load_val     <= MODE_BARS;
      mode         <= MODE_BARS;
      mode_changed <= 1'b0;
    end else begin
      vb_pulse <= (hcount == '0) && (vcount == 10'(V_ACTIVE));

      if (!auto_en || btn_press || load_req)
        frame_cnt <= '0;
      else if (vb_pulse)
        frame_cnt <= auto_exp ? '0 : frame_cnt + 1'b1;

      // A request in the vb_pulse cycle survives the clear for next frame.
      next_pend <= btn_press | (next_pend & ~vb_pulse);

      if (load_req) begin
        load_pend <= 1'b1;
        load_val  <= load_mode;
      end else if (vb_pulse) begin
        load_pend <= 1'b0;
      end

      mode_changed <= 1'b0;
      if (vb_pulse) begin
        mode         <= mode_nx;
        mode_changed <= (mode_nx != mode);
      end
    end
  end

endmodule

// File: tb/tb_tpg_mode_ctrl.sv
// Directed bench for tpg_mode_ctrl with a short frame and a queue of
// expected modes popped on every mode_changed pulse.
module tb_tpg_mode_ctrl;
  import tpg_pkg::*;

  localparam int VA = 6;
  localparam int HT = 16;
  localparam int VT = 8;

  logic       clk_pix = 1'b0;
  logic       resetn = 1'b0;
  logic [9:0] hcount = '0;
  logic [9:0] vcount = '0;
  logic       btn_next = 1'b0;
  logic       auto_en = 1'b0;
  logic       load_req = 1'b0;
  logic [1:0] load_mode = '0;
  logic [1:0] mode;
  logic       mode_changed;
  logic       pending;

  int n_cmp = 0;
  int n_err = 0;
  int press_cnt = 0;
  logic [1:0] exp_q[$];

  tpg_mode_ctrl #(
    .V_ACTIVE(VA),
    .DEBOUNCE_CYCLES(8),
    .AUTO_FRAMES(3),
    .NUM_MODES(4)
  ) u_dut (
    .clk_pix     (clk_pix),
    .resetn      (resetn),
    .hcount      (hcount),
    .vcount      (vcount),
    .btn_next    (btn_next),
    .auto_en     (auto_en),
    .load_req    (load_req),
    .load_mode   (load_mode),
    .mode        (mode),
    .mode_changed(mode_changed),
    .pending     (pending)
  );

  always #20 clk_pix = ~clk_pix;

  always @(posedge clk_pix) begin
    if (hcount == 10'(HT - 1)) begin
      hcount <= '0;
      vcount <= (vcount == 10'(VT - 1)) ? '0 : vcount + 1'b1;
    end else begin
      hcount <= hcount + 1'b1;
    end
  end

  always @(negedge clk_pix) begin
    if (resetn && u_dut.btn_press)
      press_cnt <= press_cnt + 1;
  end

  always @(negedge clk_pix) begin
    logic [1:0] e;
    if (resetn && mode_changed) begin
      e = 2'bxx;
      if (exp_q.size() != 0)
        e = exp_q.pop_front();
      n_cmp++;
      assert (mode === e) else begin
        n_err++;
        $error("FAIL sb_mode: got %0h expected %0h", mode, e);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Returns at the negedge where the vblank update is visible.
  task automatic wait_vb();
    int n = 0;
    do begin
      @(negedge clk_pix);
      n++;
    end while (!(hcount == 10'd2 && vcount == 10'(VA)) && n < 400);
    assert (n < 400) else begin
      n_err++;
      $error("FAIL vb_wait: got %0d cycles expected <400", n);
    end
  endtask

  task automatic hold(input logic lvl, input int n);
    btn_next = lvl;
    repeat (n) @(negedge clk_pix);
  endtask

  task automatic load(input logic [1:0] v);
    load_mode = v;
    load_req = 1'b1;
    @(negedge clk_pix);
    load_req = 1'b0;
  endtask

  initial begin
    logic [1:0] m;
    int lat;

    // Reset state and idle frames
    repeat (3) @(negedge clk_pix);
    chk("rst_mode", mode, 0);
    chk("rst_pending", pending, 0);
    chk("rst_changed", mode_changed, 0);
    resetn = 1'b1;
    for (int f = 0; f < 5; f++) begin
      wait_vb();
      chk("idle_mode", mode, 0);
      chk("idle_pending", pending, 0);
    end

    // Bouncy button then a solid press mid-frame
    press_cnt = 0;
    hold(1, 3); hold(0, 3); hold(1, 3); hold(0, 3);
    hold(1, 20);
    chk("press_once", press_cnt, 1);
    chk("btn_pending", pending, 1);
    chk("no_early_change", mode, 0);
    hold(0, 14);
    chk("no_release_press", press_cnt, 1);
    exp_q.push_back(2'd1);
    wait_vb();
    chk("btn_mode", mode, 1);
    chk("btn_pend_clr", pending, 0);

    // Back to mode 0, then auto-cycle for 13 frames
    load(2'd0);
    exp_q.push_back(2'd0);
    wait_vb();
    chk("load0_mode", mode, 0);
    auto_en = 1'b1;
    m = 2'd0;
    for (int k = 1; k <= 13; k++) begin
      if (k % 3 == 0) begin
        m = m + 2'd1;
        exp_q.push_back(m);
      end
      wait_vb();
      chk("auto_mode", mode, m);
    end

    // Two loads plus a press in one frame; dwell restarts
    load(2'd2);
    load(2'd3);
    chk("load_pending", pending, 1);
    hold(1, 14);
    hold(0, 14);
    chk("multi_pending", pending, 1);
    exp_q.push_back(2'd3);
    wait_vb();
    chk("load_wins", mode, 3);
    chk("load_pend_clr", pending, 0);
    wait_vb();
    chk("dwell_restart", mode, 3);
    exp_q.push_back(2'd0);
    wait_vb();
    chk("dwell_expire", mode, 0);
    auto_en = 1'b0;

    // Loading the current mode is silent
    load(2'd0);
    chk("same_pending", pending, 1);
    wait_vb();
    chk("same_no_pulse", mode_changed, 0);
    chk("same_pend_clr", pending, 0);
    chk("same_mode", mode, 0);

    // Reset while a press is queued and the button is held
    load(2'd2);
    exp_q.push_back(2'd2);
    wait_vb();
    chk("pre_rst_mode", mode, 2);
    btn_next = 1'b1;
    lat = 0;
    do begin
      @(negedge clk_pix);
      lat++;
    end while (!pending && lat < 40);
    chk("held_pending", pending, 1);
    #5 resetn = 1'b0;
    #1;
    chk("async_mode", mode, 0);
    chk("async_pending", pending, 0);
    chk("async_changed", mode_changed, 0);
    repeat (3) @(negedge clk_pix);
    resetn = 1'b1;
    lat = 0;
    do begin
      @(negedge clk_pix);
      lat++;
    end while (!u_dut.btn_press && lat < 40);
    chk("press_latency", (lat >= 10 && lat <= 12), 1);
    exp_q.push_back(2'd1);
    wait_vb();
    chk("post_rst_mode", mode, 1);
    hold(0, 16);
    chk("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
